// File: rtl/ics307_load_scheduler_pkg.sv
// Shared definitions for ICS307 load sequencing: PLL indices, sequencer states,
// and the modulo-3 index step used by both the arbiter and the sequencer.
package ics307_load_scheduler_pkg;

   localparam int unsigned NUM_PLL = 3;

   localparam logic [1:0] PLL0 = 2'd0;
   localparam logic [1:0] PLL1 = 2'd1;
   localparam logic [1:0] PLL2 = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_XFER,
      RST,
      SETTLE,
      ACK
   } state_t;

   function automatic logic [1:0] pll_next(input logic [1:0] idx, input int unsigned step);
      int unsigned sum;
      sum = 32'(idx) + step;
      return 2'(sum % NUM_PLL);
   endfunction

endpackage

// File: rtl/ics307_load_scheduler_rr_arbiter3.sv
// Combinational round-robin pick among three PLL requests, starting at ptr.
module rr_arbiter3
   import ics307_load_scheduler_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] gnt,
   output logic [1:0] idx,
   output logic       valid
);

   logic [1:0] cand;
   logic [2:0] cand_oh;

   always_comb begin
      gnt     = '0;
      idx     = PLL0;
      valid   = 1'b0;
      cand    = PLL0;
      cand_oh = '0;
      for (int unsigned k = 0; k < NUM_PLL; k++) begin
         cand    = pll_next(ptr, k);
         cand_oh = 3'b001 << cand;
         if (!valid && ((req & cand_oh) != '0)) begin
            valid = 1'b1;
            gnt   = cand_oh;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/ics307_load_scheduler.sv
// Sequences programming of three ICS307 PLLs over one shared shifter:
// grant, launch transfer, pulse PLL reset, settle, then acknowledge.
module ics307_load_scheduler
   import ics307_load_scheduler_pkg::*;
#(
   parameter int unsigned RESET_CYCLES   = 64,
   parameter int unsigned SETTLE_CYCLES  = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 8192
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req,
   input  logic       xferDone,
   output logic       xferStart,
   output logic [1:0] xferSel,
   output logic [2:0] pllReset,
   output logic [2:0] ack,
   output logic [2:0] grant,
   output logic       busy,
   output logic [2:0] timeoutErr,
   input  logic       clearErr
);

   localparam logic [15:0] RST_LOAD    = 16'(RESET_CYCLES - 1);
   localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [15:0] counter;
   logic [1:0]  rr_ptr;
   logic [2:0]  arb_gnt;
   logic [1:0]  arb_idx;
   logic        arb_valid;

   rr_arbiter3 u_arb (
      .req   (req),
      .ptr   (rr_ptr),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         counter    <= '0;
         rr_ptr     <= PLL0;
         xferStart  <= 1'b0;
         xferSel    <= PLL0;
         pllReset   <= '0;
         ack        <= '0;
         grant      <= '0;
         busy       <= 1'b0;
         timeoutErr <= '0;
      end else begin
         xferStart <= 1'b0;
         ack       <= '0;
         if (clearErr) timeoutErr <= '0;

         case (state)
            IDLE: begin
               if (arb_valid) begin
                  grant   <= arb_gnt;
                  xferSel <= arb_idx;
                  busy    <= 1'b1;
                  state   <= START;
               end
            end
            START: begin
               xferStart <= 1'b1;
               counter   <= '0;
               state     <= WAIT_XFER;
            end
            WAIT_XFER: begin
               // Completion takes priority over a timeout expiring on the same clock.
               if (xferDone) begin
                  pllReset <= grant;
                  counter  <= RST_LOAD;
                  state    <= RST;
               end else if (counter == TO_LAST) begin
                  timeoutErr <= (clearErr ? 3'b000 : timeoutErr) | grant;
                  ack        <= grant;
                  state      <= ACK;
               end else if (counter != '1) begin
                  counter <= counter + 16'd1;
               end
            end
            RST: begin
               if (counter == '0) begin
                  pllReset <= '0;
                  counter  <= SETTLE_LOAD;
                  state    <= SETTLE;
               end else begin
                  counter <= counter - 16'd1;
               end
            end
            SETTLE: begin
               // ack is registered on entry so it is high exactly while in ACK.
               if (counter == '0) begin
                  ack   <= grant;
                  state <= ACK;
               end else begin
                  counter <= counter - 16'd1;
               end
            end
            ACK: begin
               rr_ptr <= pll_next(xferSel, 1);
               grant  <= '0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ics307_load_scheduler.sv
// Directed self-checking bench for ics307_load_scheduler with default timing.
module tb_ics307_load_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] req = '0;
   logic       xferDone = 1'b0;
   logic       clearErr = 1'b0;
   logic       xferStart;
   logic [1:0] xferSel;
   logic [2:0] pllReset;
   logic [2:0] ack;
   logic [2:0] grant;
   logic       busy;
   logic [2:0] timeoutErr;

   int n_assert = 0;
   int n_fail   = 0;
   int prst_cnt = 0;
   bit onehot_bad = 1'b0;

   ics307_load_scheduler #(
      .RESET_CYCLES   (64),
      .SETTLE_CYCLES  (1024),
      .TIMEOUT_CYCLES (8192)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .xferDone   (xferDone),
      .xferStart  (xferStart),
      .xferSel    (xferSel),
      .pllReset   (pllReset),
      .ack        (ack),
      .grant      (grant),
      .busy       (busy),
      .timeoutErr (timeoutErr),
      .clearErr   (clearErr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pllReset != '0) prst_cnt++;
      if (!$onehot0(grant) || !$onehot0(pllReset)) onehot_bad = 1'b1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no end of test, required finish before 1000000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic bit hit(input int which);
      case (which)
         0:       return xferStart;
         1:       return ack != '0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input int which, input int limit, output int cyc);
      cyc = 0;
      while (!hit(which) && cyc < limit) begin
         tick(1);
         cyc++;
      end
   endtask

   task automatic serve(input string tag, input logic [1:0] idx, input int done_dly);
      int cyc;
      logic [2:0] oh;
      oh = 3'b001 << idx;
      wait_for(0, 20, cyc);
      chk({tag, "_start"}, 32'(xferStart), 32'd1);
      chk({tag, "_sel"}, 32'(xferSel), 32'(idx));
      chk({tag, "_grant"}, 32'(grant), 32'(oh));
      tick(done_dly);
      xferDone = 1'b1;
      tick(1);
      xferDone = 1'b0;
      chk({tag, "_prst"}, 32'(pllReset), 32'(oh));
      wait_for(1, 2000, cyc);
      chk({tag, "_ack"}, 32'(ack), 32'(oh));
   endtask

   initial begin
      int cnt;
      int cyc;
      int p0;

      tick(2);
      chk("reset_outs", 32'({xferStart, xferSel, pllReset, ack, grant, busy, timeoutErr}), 32'd0);
      reset = 1'b1;
      tick(2);

      // single request on PLL1
      req = 3'b010;
      tick(1);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_nostart", 32'(xferStart), 32'd0);
      tick(1);
      chk("t1_start", 32'(xferStart), 32'd1);
      chk("t1_sel", 32'(xferSel), 32'd1);
      tick(200);
      xferDone = 1'b1;
      tick(1);
      xferDone = 1'b0;
      chk("t1_prst", 32'(pllReset), 32'b010);
      cnt = 0;
      while (pllReset[1] && cnt < 200) begin
         cnt++;
         tick(1);
      end
      chk("t1_prst_len", 32'(cnt), 32'd64);
      cnt = 0;
      while (ack == '0 && cnt < 2000) begin
         tick(1);
         cnt++;
      end
      chk("t1_settle_len", 32'(cnt), 32'd1024);
      chk("t1_ack", 32'(ack), 32'b010);
      req = 3'b000;
      tick(1);
      chk("t1_ack_pulse", 32'(ack), 32'd0);
      tick(1);
      chk("t1_idle", 32'({busy, grant}), 32'd0);

      // round robin from a fresh pointer
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(1);
      req = 3'b111;
      serve("rr0", 2'd0, 5);
      serve("rr1", 2'd1, 5);
      serve("rr2", 2'd2, 5);
      serve("rr3", 2'd0, 5);
      req = 3'b000;
      chk("rr_onehot", 32'(onehot_bad), 32'd0);
      tick(3);

      // timeout on PLL0
      req = 3'b001;
      wait_for(0, 20, cyc);
      chk("to_latency", 32'(cyc), 32'd2);
      p0 = prst_cnt;
      tick(8191);
      chk("to_before", 32'({timeoutErr, ack}), 32'd0);
      tick(1);
      chk("to_err", 32'(timeoutErr), 32'b001);
      chk("to_ack", 32'(ack), 32'b001);
      chk("to_noprst", 32'(prst_cnt - p0), 32'd0);
      req = 3'b000;
      tick(1);
      chk("to_ack_pulse", 32'(ack), 32'd0);
      tick(3);
      chk("to_sticky", 32'(timeoutErr), 32'b001);
      clearErr = 1'b1;
      tick(1);
      clearErr = 1'b0;
      chk("to_clear", 32'(timeoutErr), 32'd0);

      // xferDone on the timeout-expiry clock counts as success
      req = 3'b001;
      wait_for(0, 20, cyc);
      chk("bd_latency", 32'(cyc), 32'd2);
      tick(8191);
      xferDone = 1'b1;
      tick(1);
      xferDone = 1'b0;
      chk("bd_noerr", 32'(timeoutErr), 32'd0);
      chk("bd_prst", 32'(pllReset), 32'b001);
      wait_for(1, 2000, cyc);
      chk("bd_ack_time", 32'(cyc), 32'd1088);
      chk("bd_ack", 32'(ack), 32'b001);
      chk("bd_noerr2", 32'(timeoutErr), 32'd0);
      req = 3'b000;
      tick(3);

      // spurious xferDone while idle
      xferDone = 1'b1;
      tick(1);
      xferDone = 1'b0;
      chk("sp_idle", 32'({busy, xferStart, grant, pllReset, ack, timeoutErr}), 32'd0);
      tick(2);
      chk("sp_idle2", 32'({busy, xferStart, grant, pllReset, ack, timeoutErr}), 32'd0);

      // asynchronous reset during RST on PLL2
      req = 3'b100;
      wait_for(0, 20, cyc);
      chk("mr_sel", 32'(xferSel), 32'd2);
      tick(3);
      xferDone = 1'b1;
      tick(1);
      xferDone = 1'b0;
      tick(10);
      chk("mr_prst", 32'(pllReset), 32'b100);
      #1 reset = 1'b0;
      #1;
      chk("mr_async_prst", 32'(pllReset), 32'd0);
      chk("mr_async_busy", 32'(busy), 32'd0);
      tick(1);
      chk("mr_held", 32'({xferStart, xferSel, pllReset, ack, grant, busy, timeoutErr}), 32'd0);
      reset = 1'b1;
      tick(1);
      chk("mr_restart_busy", 32'({busy, xferStart}), 32'b10);
      tick(1);
      chk("mr_restart", 32'(xferStart), 32'd1);
      chk("mr_restart_sel", 32'(xferSel), 32'd2);
      tick(3);
      xferDone = 1'b1;
      tick(1);
      xferDone = 1'b0;
      wait_for(1, 2000, cyc);
      chk("mr_ack", 32'(ack), 32'b100);
      req = 3'b000;
      tick(3);

      // request withdrawn mid-transfer still completes
      req = 3'b011;
      wait_for(0, 20, cyc);
      chk("wd_sel", 32'(xferSel), 32'd0);
      req = 3'b010;
      tick(4);
      xferDone = 1'b1;
      tick(1);
      xferDone = 1'b0;
      wait_for(1, 2000, cyc);
      chk("wd_ack", 32'(ack), 32'b001);
      serve("wd2", 2'd1, 10);
      req = 3'b000;
      chk("wd_onehot", 32'(onehot_bad), 32'd0);
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
